// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types and constants for the ID/EX register
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Decode-stage control bundle, MSB first in decoder port order
   typedef struct packed {
      logic       RegWrite;
      logic       MemWrite;
      logic       Branch;
      logic       Jump;
      logic       JumpALR;
      logic       ALUSrc;
      logic [1:0] ResultSrc;
      logic [3:0] ALUControl;
   } ctrl_t;

   // A bubble is an all-zero control word: no writes, no branches
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - width-parameterized flop with async reset, sync clear and enable
module flopenrc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Clear beats enable so a flush still lands while the stage is stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   data_q <= '0;
      else if (clr_i) data_q <= '0;
      else if (en_i)  data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/idex_reg.sv
// rtl/idex_reg.sv - ID/EX pipeline register with bubble sanitizing; IDEX_BUBBLE_CNT_EN adds a bubble counter
module idex_reg
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            ValidD,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic            BranchD,
   input  logic            JumpD,
   input  logic            JumpALRD,
   input  logic            ALUSrcD,
   input  logic [1:0]      ResultSrcD,
   input  logic [3:0]      ALUControlD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic [2:0]      funct3D,
   output logic            ValidE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            BranchE,
   output logic            JumpE,
   output logic            JumpALRE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [3:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [2:0]      funct3E,
   output logic [31:0]     BubbleCntE
);

   localparam int CW = $bits(ctrl_t) + 1;
   localparam int DW = 5 * XLEN + 18;

   ctrl_t         ctrl_in;
   ctrl_t         ctrl_e;
   logic [CW-1:0] ctrl_d;
   logic [CW-1:0] ctrl_q;
   logic [DW-1:0] data_d;
   logic [DW-1:0] data_q;

   assign ctrl_in = {RegWriteD, MemWriteD, BranchD, JumpD, JumpALRD, ALUSrcD,
                     ResultSrcD, ALUControlD};

   // An empty decode slot carries decoder don't-cares; replace them with a bubble
   assign ctrl_d = {(ValidD ? ctrl_in : CTRL_BUBBLE), ValidD};
   assign data_d = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, funct3D};

   flopenrc #(.WIDTH(CW)) u_ctrl_flop (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (~StallE),
      .clr_i   (FlushE),
      .d_i     (ctrl_d),
      .q_o     (ctrl_q)
   );

   flopenrc #(.WIDTH(DW)) u_data_flop (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (~StallE),
      .clr_i   (FlushE),
      .d_i     (data_d),
      .q_o     (data_q)
   );

   assign {ctrl_e, ValidE} = ctrl_q;
   assign RegWriteE   = ctrl_e.RegWrite;
   assign MemWriteE   = ctrl_e.MemWrite;
   assign BranchE     = ctrl_e.Branch;
   assign JumpE       = ctrl_e.Jump;
   assign JumpALRE    = ctrl_e.JumpALR;
   assign ALUSrcE     = ctrl_e.ALUSrc;
   assign ResultSrcE  = ctrl_e.ResultSrc;
   assign ALUControlE = ctrl_e.ALUControl;

   assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, funct3E} = data_q;

`ifdef IDEX_BUBBLE_CNT_EN
   logic        bubble_evt;
   logic [31:0] bubble_cnt_d;
   logic [31:0] bubble_cnt_q;

   // A held cycle never counts; flush counts even when stalled
   assign bubble_evt = FlushE | (~StallE & ~ValidD);

   // Saturating increment so a long run never wraps back to a small count
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bubble_cnt_q <= '0;
      else          bubble_cnt_q <= bubble_cnt_d;
   end

   assign BubbleCntE = bubble_cnt_q;
`else
   assign BubbleCntE = '0;
`endif

endmodule
